mc_issue_ctrl: RTL and testbench

- Opcode issue controller between instruction fetch and the microcode sequencer.
- Buffers fetched opcodes, each tagged with its JS/native mode bit, in a small FIFO.
- Presents the head opcode to the sequencer and retires it only when the current microprogram ends (more low) and the pipe is not stalled.
- On a stage-4 kill, flushes the buffer and blanks issue for a fixed drain window.

---
 rtl/mc_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_mc_issue_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_issue_ctrl.sv
// Opcode issue controller: buffers fetched opcodes and presents the head to the microcode sequencer.
// Latency: 1 cycle from fetch to opcode. Head retires only at the end of a microprogram.
// Backpressure: fe_ready drops when the FIFO is full, while flushing, or during a kill.

module mc_issue_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module mc_issue_ctrl #(
    parameter int         DEPTH        = 4,
    parameter logic [7:0] NOP_OP       = 8'h00,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fe_valid,
    input  logic [7:0]               fe_opcode,
    input  logic                     fe_js_mode,
    output logic                     fe_ready,
    input  logic                     mc__more_2a,
    input  logic                     mc__stall,
    input  logic                     kill_4a,
    output logic [7:0]               opcode,
    output logic                     js_mode,
    output logic                     issue_valid,
    output logic                     issue_fire,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic       js;
        logic [7:0] op;
    } op_ent_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    op_ent_t    push_ent, head_ent;
    logic       push;

    assign fe_ready    = (fifo_count < CW'(DEPTH)) && (state == RUN) && !kill_4a;
    assign push        = fe_valid && fe_ready;
    assign issue_valid = (state == RUN) && (fifo_count != '0);
    assign issue_fire  = issue_valid && !mc__more_2a && !mc__stall && !kill_4a;
    assign opcode      = issue_valid ? head_ent.op : NOP_OP;
    assign js_mode     = issue_valid ? head_ent.js : 1'b0;
    assign push_ent    = '{js: fe_js_mode, op: fe_opcode};

    mc_issue_fifo #(.W($bits(op_ent_t)), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (kill_4a),
        .push     (push),
        .push_dat (push_ent),
        .pop      (issue_fire),
        .head_dat (head_ent),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_cnt  <= '0;
            issued_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (issue_fire) issued_cnt <= issued_cnt + 16'd1;
        end
    end

    // A kill in either state (re)starts the full blanking window.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (kill_4a) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = 3'(FLUSH_CYCLES);
        end else if (state == FLUSH) begin
            if (flush_cnt == 3'd1) begin
                state_nxt     = RUN;
                flush_cnt_nxt = '0;
            end else begin
                flush_cnt_nxt = flush_cnt - 3'd1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == CW'(DEPTH)) && !(issue_fire && fifo_count == '0));
endmodule

// File: tb/tb_mc_issue_ctrl.sv
// Bench for mc_issue_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_mc_issue_ctrl;
    localparam int         DEPTH = 4;
    localparam logic [7:0] NOP   = 8'h00;
    localparam int         FLUSH = 2;

    logic        clk, rst, fe_valid, fe_js_mode, fe_ready;
    logic [7:0]  fe_opcode, opcode;
    logic        mc__more_2a, mc__stall, kill_4a, js_mode, issue_valid, issue_fire;
    logic [2:0]  fifo_count;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    mc_issue_ctrl #(.DEPTH(DEPTH), .NOP_OP(NOP), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst(rst), .fe_valid(fe_valid), .fe_opcode(fe_opcode),
        .fe_js_mode(fe_js_mode), .fe_ready(fe_ready), .mc__more_2a(mc__more_2a),
        .mc__stall(mc__stall), .kill_4a(kill_4a), .opcode(opcode), .js_mode(js_mode),
        .issue_valid(issue_valid), .issue_fire(issue_fire), .fifo_count(fifo_count),
        .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] op, input logic js,
                         input logic more, input logic stall, input logic kill);
        @(negedge clk);
        fe_valid = v; fe_opcode = op; fe_js_mode = js;
        mc__more_2a = more; mc__stall = stall; kill_4a = kill;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fe_valid = 0; fe_opcode = 0; fe_js_mode = 0; mc__more_2a = 0; mc__stall = 0; kill_4a = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (opcode !== NOP)        begin errors++; $display("FAIL reset_opcode got %h exp %h", opcode, NOP); end
        checks++; if (js_mode !== 1'b0)      begin errors++; $display("FAIL reset_js got %b exp 0", js_mode); end
        checks++; if (issue_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
        checks++; if (issue_fire !== 1'b0)   begin errors++; $display("FAIL reset_fire got %b exp 0", issue_fire); end
        checks++; if (fifo_count !== 3'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (fe_ready !== 1'b1)     begin errors++; $display("FAIL reset_ready got %b exp 1", fe_ready); end
        checks++; if (issued_cnt !== 16'd0)  begin errors++; $display("FAIL reset_issued got %0d exp 0", issued_cnt); end
    endtask

    task automatic test_basic_issue();
        do_reset();
        drive(1, 8'h12, 0, 0, 0, 0);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid got %b exp 0", issue_valid); end
        drive(1, 8'h34, 1, 0, 0, 0);
        checks++; if ({issue_valid, js_mode, opcode} !== {1'b1, 1'b0, 8'h12}) begin errors++; $display("FAIL basic_head0 got %b/%b/%h exp 1/0/12", issue_valid, js_mode, opcode); end
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_fire0 got %b exp 1", issue_fire); end
        drive(0, 8'h00, 0, 0, 0, 0);
        checks++; if ({issue_valid, js_mode, opcode} !== {1'b1, 1'b1, 8'h34}) begin errors++; $display("FAIL basic_head1 got %b/%b/%h exp 1/1/34", issue_valid, js_mode, opcode); end
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_fire1 got %b exp 1", issue_fire); end
        drive(0, 8'h00, 0, 0, 0, 0);
        checks++; if (issued_cnt !== 16'd2) begin errors++; $display("FAIL basic_issued got %0d exp 2", issued_cnt); end
        checks++; if ({issue_valid, opcode} !== {1'b0, NOP}) begin errors++; $display("FAIL basic_drain got %b/%h exp 0/%h", issue_valid, opcode, NOP); end
    endtask

    task automatic test_more_hold();
        do_reset();
        drive(1, 8'h21, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 0, 1, 0, 0);
            checks++; if ({opcode, issue_fire} !== {8'h21, 1'b0}) begin errors++; $display("FAIL hold_%0d got %h/%b exp 21/0", i, opcode, issue_fire); end
        end
        drive(0, 8'h00, 0, 0, 0, 0);
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", issue_fire); end
        drive(0, 8'h00, 0, 0, 0, 0);
        checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL hold_issued got %0d exp 1", issued_cnt); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 8'h40 + 8'(i), 0, 1, 0, 0);
            checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, fe_ready); end
        end
        drive(1, 8'h55, 0, 1, 0, 0);
        checks++; if ({fifo_count, fe_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_state got %0d/%b exp 4/0", fifo_count, fe_ready); end
        drive(1, 8'h55, 0, 0, 0, 0);
        checks++; if ({issue_fire, fe_ready} !== {1'b1, 1'b0}) begin errors++; $display("FAIL full_pop_push got %b/%b exp 1/0", issue_fire, fe_ready); end
        drive(0, 8'h00, 0, 1, 0, 0);
        checks++; if ({fifo_count, opcode, fe_ready} !== {3'd3, 8'h41, 1'b1}) begin errors++; $display("FAIL full_after got %0d/%h/%b exp 3/41/1", fifo_count, opcode, fe_ready); end
    endtask

    task automatic test_kill();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 8'h60 + 8'(i), 1, 1, 0, 0);
        drive(1, 8'h70, 0, 0, 0, 1);
        checks++; if ({fe_ready, issue_fire} !== 2'b00) begin errors++; $display("FAIL kill_cycle got %b/%b exp 0/0", fe_ready, issue_fire); end
        for (int i = 0; i < FLUSH; i++) begin
            drive(1, 8'h70, 0, 0, 0, 0);
            checks++; if ({fifo_count, issue_valid, fe_ready, opcode} !== {3'd0, 1'b0, 1'b0, NOP}) begin errors++; $display("FAIL kill_blank_%0d got %0d/%b/%b/%h exp 0/0/0/%h", i, fifo_count, issue_valid, fe_ready, opcode, NOP); end
        end
        drive(1, 8'h70, 0, 0, 0, 0);
        checks++; if ({fe_ready, fifo_count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL kill_resume got %b/%0d exp 1/0", fe_ready, fifo_count); end
        checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL kill_issued got %0d exp 0", issued_cnt); end
    endtask

    task automatic test_double_kill();
        do_reset();
        drive(1, 8'h11, 0, 1, 0, 0);
        drive(0, 8'h00, 0, 1, 0, 1);
        drive(0, 8'h00, 0, 1, 0, 1);
        checks++; if (fe_ready !== 1'b0) begin errors++; $display("FAIL dkill_second got %b exp 0", fe_ready); end
        for (int i = 0; i < FLUSH; i++) begin
            drive(0, 8'h00, 0, 1, 0, 0);
            checks++; if (fe_ready !== 1'b0) begin errors++; $display("FAIL dkill_blank_%0d got %b exp 0", i, fe_ready); end
        end
        drive(0, 8'h00, 0, 1, 0, 0);
        checks++; if (fe_ready !== 1'b1) begin errors++; $display("FAIL dkill_resume got %b exp 1", fe_ready); end
    endtask

    task automatic test_wrap();
        int unsigned fired = 0;
        logic [15:0] exp_cnt = 16'd0;
        logic        stall, exp_fire;
        do_reset();
        for (int i = 0; i < 70000 && fired < 65538; i++) begin
            stall = (fired >= 65525) ? logic'(i & 1) : 1'b0;
            drive(1, 8'($urandom), 1'($urandom), 0, stall, 0);
            exp_fire = (i > 0) && !stall;
            if (fired >= 65525) begin
                checks++; if (issue_fire !== exp_fire) begin errors++; $display("FAIL wrap_fire got %b exp %b", issue_fire, exp_fire); end
                checks++; if (issued_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt got %0d exp %0d", issued_cnt, exp_cnt); end
            end
            if (exp_fire) begin fired++; exp_cnt = exp_cnt + 16'd1; end
        end
        drive(0, 8'h00, 0, 1, 0, 0);
        checks++; if (issued_cnt !== 16'd2) begin errors++; $display("FAIL wrap_final got %0d exp 2", issued_cnt); end
    endtask

    task automatic test_random();
        logic [8:0]  q[$];
        int          blank = 0;
        logic [15:0] cnt_m = 16'd0;
        logic        v, js, more, stall, kill, run, e_valid, e_ready, e_fire;
        logic [7:0]  op, e_op;
        logic        e_js;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = 1'($urandom); op = 8'($urandom); js = 1'($urandom);
            more = ($urandom_range(0, 2) == 0); stall = ($urandom_range(0, 3) == 0);
            kill = ($urandom_range(0, 19) == 0);
            drive(v, op, js, more, stall, kill);
            run     = (blank == 0);
            e_valid = run && (q.size() > 0);
            e_op    = e_valid ? q[0][7:0] : NOP;
            e_js    = e_valid ? q[0][8] : 1'b0;
            e_ready = (q.size() < DEPTH) && run && !kill;
            e_fire  = e_valid && !more && !stall && !kill;
            checks++; if ({issue_valid, opcode, js_mode} !== {e_valid, e_op, e_js}) begin errors++; $display("FAIL rnd_head @%0d got %b/%h/%b exp %b/%h/%b", i, issue_valid, opcode, js_mode, e_valid, e_op, e_js); end
            checks++; if ({fe_ready, issue_fire} !== {e_ready, e_fire}) begin errors++; $display("FAIL rnd_hs @%0d got %b/%b exp %b/%b", i, fe_ready, issue_fire, e_ready, e_fire); end
            checks++; if ({fifo_count, issued_cnt} !== {3'(q.size()), cnt_m}) begin errors++; $display("FAIL rnd_cnt @%0d got %0d/%0d exp %0d/%0d", i, fifo_count, issued_cnt, q.size(), cnt_m); end
            if (kill) begin
                q.delete();
                blank = FLUSH;
            end else begin
                if (e_fire) void'(q.pop_front());
                if (v && e_ready) q.push_back({js, op});
                if (blank > 0) blank--;
            end
            if (e_fire) cnt_m = cnt_m + 16'd1;
        end
    endtask

    initial begin
        rst = 1'b1;
        fe_valid = 0; fe_opcode = 0; fe_js_mode = 0; mc__more_2a = 0; mc__stall = 0; kill_4a = 0;
        test_reset();
        test_basic_issue();
        test_more_hold();
        test_full();
        test_kill();
        test_double_kill();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
